// File: rtl/chacha_pkg.sv
// chacha_pkg: shared ChaCha constants, index types and unloader state encoding
package chacha_pkg;
  localparam int CHACHA_WORDS = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
  typedef logic [3:0] word_idx_t;
  typedef logic [1:0] byte_idx_t;
  typedef enum logic {EMPTY, SHIFT} state_t;
endpackage

// File: rtl/chacha_state_unloader.sv
// chacha_state_unloader: drains 32-bit state words as a little-endian byte stream with block framing
module chacha_state_unloader import chacha_pkg::*; #(
  parameter int WORDS = CHACHA_WORDS,
  parameter int BLK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_first,
  output logic                 byte_last,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_count
);
  localparam int WIW = $clog2(WORDS);
  localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_WORD - 1);
  state_t state, state_nxt;
  logic [31:0] hold;
  byte_idx_t byte_idx;
  logic [WIW-1:0] word_idx;
  logic accept_w, accept_b, word_done;
  assign accept_w = word_valid & word_ready;
  assign accept_b = byte_valid & byte_ready;
  assign word_done = accept_b & (byte_idx == LAST_BYTE);
  assign byte_valid = state == SHIFT;
  // Reload in the same cycle the last byte leaves, so words stream without a bubble
  assign word_ready = !flush & ((state == EMPTY) | word_done);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nxt;
  always_comb
    state_nxt = flush ? EMPTY :
                (state == EMPTY) ? (accept_w ? SHIFT : EMPTY) :
                (word_done & !accept_w) ? EMPTY : SHIFT;
  always_comb begin
    byte_out = hold[7:0];
    byte_first = byte_valid & (byte_idx == '0) & (word_idx == '0);
    byte_last = byte_valid & (byte_idx == LAST_BYTE) & (&word_idx);
    busy = byte_valid | (word_idx != '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      blk_count <= '0;
    end else if (flush) begin
      byte_idx <= '0;
      word_idx <= '0;
    end else begin
      if (accept_w) begin
        hold <= word_in;
        byte_idx <= '0;
      end else if (accept_b) begin
        hold <= hold >> 8;
        byte_idx <= byte_idx + 2'd1;
      end
      if (word_done) word_idx <= word_idx + WIW'(1);
      if (accept_b & byte_last) blk_count <= blk_count + BLK_CNT_W'(1);
    end
endmodule

// File: tb/tb_chacha_state_unloader.sv
// tb_chacha_state_unloader: byte-queue reference model plus table vectors and corner sequences
module tb_chacha_state_unloader;
  import chacha_pkg::*;
  typedef struct { logic [7:0] b; bit f; bit l; } ebyte_t;
  typedef struct packed { logic [31:0] w; logic [0:3][7:0] e; } vec_t;
  logic clk = 0, rst = 1, flush = 0, word_valid = 0, byte_ready = 0;
  logic [31:0] word_in = 0;
  logic word_ready, byte_valid, byte_first, byte_last, busy;
  logic [7:0] byte_out, blk_count;
  logic word_ready2, byte_valid2, byte_first2, byte_last2, busy2;
  logic [7:0] byte_out2;
  logic [1:0] blk_count2;
  int checks = 0, errors = 0, cyc = 0;
  ebyte_t q[$];
  int m_words = 0, m_blks = 0;
  logic [31:0] blk_words [16];
  int nb = 0, first_cyc = 0, last_cyc = 0;
  bit acc_w, acc_b;

  always #5 clk = ~clk;

  chacha_state_unloader dut (
    .clk(clk), .rst(rst), .flush(flush), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_first(byte_first), .byte_last(byte_last), .busy(busy), .blk_count(blk_count));

  chacha_state_unloader #(.WORDS(16), .BLK_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready2), .byte_out(byte_out2), .byte_valid(byte_valid2), .byte_ready(byte_ready),
    .byte_first(byte_first2), .byte_last(byte_last2), .busy(busy2), .blk_count(blk_count2));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare outputs with the model, advance the model, move to the next falling edge
  task automatic cycle();
    bit bv, wr, bz;
    ebyte_t e;
    #1;
    bv = q.size() != 0;
    wr = !flush && (!bv || (byte_ready && q.size() == 1));
    bz = bv || m_words != 0;
    chk("byte_valid", byte_valid, bv);
    if (bv) chk("byte_first_last", {byte_out, byte_first, byte_last}, {q[0].b, q[0].f, q[0].l});
    chk("busy", busy, bz);
    chk("word_ready", word_ready, wr);
    chk("blk_count", blk_count, m_blks % 256);
    chk("dut2", {byte_valid2, busy2, word_ready2, blk_count2}, {bv, bz, wr, 2'(m_blks % 4)});
    acc_b = 0;
    acc_w = 0;
    if (flush) begin
      q.delete();
      m_words = 0;
    end else begin
      acc_b = bv && byte_ready;
      acc_w = word_valid && wr;
      if (acc_b) begin
        if (q[0].l) m_blks++;
        void'(q.pop_front());
        if (nb == 0) first_cyc = cyc;
        last_cyc = cyc;
        nb++;
      end
      if (acc_w) begin
        for (int k = 0; k < 4; k++) begin
          e.b = word_in[8*k +: 8];
          e.f = m_words == 0 && k == 0;
          e.l = m_words == 15 && k == 3;
          q.push_back(e);
        end
        m_words = (m_words + 1) % 16;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_block(int n, bit rnd, int flush_at);
    int wi = 0;
    int t = 0;
    bit fl = 0;
    nb = 0;
    while (!fl && !(wi == n && q.size() == 0) && t < 3000) begin
      fl = flush_at >= 0 && nb == flush_at && q.size() != 0;
      flush = fl;
      byte_ready = fl || !rnd || ($urandom_range(3) != 0);
      word_valid = wi < n && (!rnd || $urandom_range(3) != 0);
      word_in = blk_words[wi % 16];
      cycle();
      if (acc_w) wi++;
      t++;
    end
    flush = 0;
    word_valid = 0;
    chk("block_timeout", t < 3000, 1);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 16; i++) blk_words[i] = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl [4];
    logic [7:0] bp [4];
    int exp2 [4];
    tbl[0] = '{32'h61707865, {8'h65, 8'h78, 8'h70, 8'h61}};
    tbl[1] = '{32'h3320646e, {8'h6e, 8'h64, 8'h20, 8'h33}};
    tbl[2] = '{32'h79622d32, {8'h32, 8'h2d, 8'h62, 8'h79}};
    tbl[3] = '{32'h6b206574, {8'h74, 8'h65, 8'h20, 8'h6b}};
    bp = '{8'h6e, 8'h64, 8'h20, 8'h33};
    exp2 = '{1, 2, 3, 0};
    @(negedge clk);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_first", byte_first, 0);
    chk("rst_last", byte_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_count", blk_count, 0);
    rst = 0;
    #1 chk("rst_word_ready", word_ready, 1);
    // Table: single words, bytes must appear LSB first from the cycle after acceptance
    for (int i = 0; i < 4; i++) begin
      word_in = tbl[i].w;
      word_valid = 1;
      byte_ready = 1;
      cycle();
      word_valid = 0;
      for (int k = 0; k < 4; k++) begin
        #1;
        chk("tbl_byte", byte_out, tbl[i].e[k]);
        chk("tbl_first", byte_first, i == 0 && k == 0);
        chk("tbl_last", byte_last, 0);
        cycle();
      end
    end
    flush = 1;
    cycle();
    flush = 0;
    #1 chk("flush_busy", busy, 0);
    // Full block, continuous handshakes
    for (int i = 0; i < 16; i++) blk_words[i] = i < 4 ? SIGMA[i] : 32'(i - 4);
    run_block(16, 0, -1);
    chk("full_bytes", nb, 64);
    chk("full_bubbles", last_cyc - first_cyc, 63);
    chk("full_blk_count", blk_count, 1);
    #1 chk("full_busy", busy, 0);
    // Backpressure on a word while the next word waits
    word_in = 32'h3320646e;
    word_valid = 1;
    byte_ready = 0;
    cycle();
    word_in = 32'h11223344;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_hold", byte_out, 8'h6e);
      chk("bp_word_ready", word_ready, 0);
      cycle();
    end
    byte_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_order", byte_out, bp[k]);
      chk("bp_ready_release", word_ready, k == 3);
      cycle();
    end
    word_valid = 0;
    for (int k = 0; k < 4; k++) cycle();
    flush = 1;
    cycle();
    flush = 0;
    // Flush mid-block, then a fresh block
    rand_words();
    run_block(16, 1, 37);
    chk("f37_count", blk_count, 1);
    rand_words();
    run_block(16, 1, -1);
    chk("f37_new_count", blk_count, 2);
    // Flush on the very cycle byte_last is accepted: not counted
    rand_words();
    run_block(16, 1, 63);
    chk("flush_last_count", blk_count, 2);
    // Asynchronous reset mid-word
    word_in = 32'hdeadbeef;
    word_valid = 1;
    byte_ready = 1;
    cycle();
    word_valid = 0;
    cycle();
    cycle();
    rst = 1;
    #1;
    chk("arst_byte_valid", byte_valid, 0);
    chk("arst_blk_count", blk_count, 0);
    q.delete();
    m_words = 0;
    m_blks = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1 chk("arst_word_ready", word_ready, 1);
    word_in = 32'ha5c31e77;
    word_valid = 1;
    cycle();
    word_valid = 0;
    #1;
    chk("arst_first", byte_first, 1);
    chk("arst_byte0", byte_out, 8'h77);
    for (int k = 0; k < 4; k++) cycle();
    flush = 1;
    cycle();
    flush = 0;
    // Counter wrap on the 2-bit instance
    for (int b = 0; b < 4; b++) begin
      rand_words();
      run_block(16, 1, -1);
      chk("wrap_count2", blk_count2, exp2[b]);
      chk("wrap_count", blk_count, b + 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
